// File: rtl/smi_frame_rx_if.sv
// Pixel stream from the SMI frame parser to the LED driver.
// Valid/ready handshake; the head word is presented first-word-fall-through.
interface smi_frame_rx_if #(
  parameter int unsigned PX_W = 24
);
  logic [PX_W-1:0] px_data;
  logic            px_last;
  logic            px_valid;
  logic            px_ready;

  modport master (
    output px_data,
    output px_last,
    output px_valid,
    input  px_ready
  );

  modport slave (
    input  px_data,
    input  px_last,
    input  px_valid,
    output px_ready
  );
endinterface

// File: rtl/smi_frame_rx.sv
// SMI byte-stream frame parser: sync, 16-bit pixel count, then pixel bytes packed MSB-first
// into pixel words that are buffered in a first-word-fall-through FIFO.
module smi_frame_rx #(
  parameter int unsigned BYTES_PER_PIXEL = 3,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_write,
  smi_frame_rx_if.master        px,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned PW = 8 * BYTES_PER_PIXEL;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_PIXEL - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    PIXEL
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     len_hi_q, len_hi_d;
  logic [15:0]    remaining_q, remaining_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  pix_word;
  logic           sync_hit;
  logic           push;
  logic           push_last;
  logic           done_d;

  // Parser next-state and per-byte strobes
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sync_hit    = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    done_d      = 1'b0;
    // Truncating cast keeps only the newest BYTES_PER_PIXEL bytes (also valid for 1 byte/pixel).
    pix_word    = PW'({acc_q, in_data});

    if (in_write) begin
      case (state_q)
        IDLE: begin
          if (in_data == SYNC_BYTE) begin
            sync_hit = 1'b1;
            state_d  = LEN_HI;
          end
        end
        LEN_HI: begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
        LEN_LO: begin
          if ({len_hi_q, in_data} == 16'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remaining_d = {len_hi_q, in_data};
            idx_d       = '0;
            state_d     = PIXEL;
          end
        end
        PIXEL: begin
          acc_d = pix_word;
          if (idx_q == LAST_IDX) begin
            push        = 1'b1;
            push_last   = (remaining_q == 16'd1);
            idx_d       = '0;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_hi_q    <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      frame_start <= sync_hit;
      frame_done  <= done_d;
      busy        <= (state_d != IDLE);
    end
  end

  logic [PW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [PW:0]   head;

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign full  = (count == FULL_CNT);
  assign pop   = (count != '0) & px.px_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {push_last, pix_word};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (sync_hit) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head is masked while empty so outputs read zero after reset despite unreset storage.
  assign head        = mem[rd_ptr];
  assign px.px_valid = (count != '0);
  assign px.px_data  = px.px_valid ? head[PW-1:0] : '0;
  assign px.px_last  = px.px_valid ? head[PW] : 1'b0;

endmodule

// File: tb/tb_smi_frame_rx.sv
// Directed bench for smi_frame_rx: framing, zero-length frames, overflow, full-FIFO pass-through,
// asynchronous reset mid-frame and sync-valued payload bytes.
module tb_smi_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_write = 1'b0;
  logic       frame_start, frame_done, overflow, busy;

  smi_frame_rx_if #(.PX_W(24)) px_if ();

  smi_frame_rx #(
    .BYTES_PER_PIXEL(3),
    .FIFO_DEPTH(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_write(in_write),
    .px(px_if.master),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;

  logic [23:0] got_data [$];
  logic        got_last [$];

  // Record every pixel that will be popped on the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (px_if.px_valid && px_if.px_ready) begin
      got_data.push_back(px_if.px_data);
      got_last.push_back(px_if.px_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // After step returns, outputs reflect every byte driven by earlier steps.
  task automatic step(input logic w, input logic [7:0] b);
    @(negedge clk);
    in_write = w;
    in_data  = b;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  function automatic logic [23:0] pat(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb, 8'h5A, ~kb};
  endfunction

  initial begin
    logic [23:0] p;
    int          n_last;

    px_if.px_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", px_if.px_valid, 0);
    chk("rst_last", px_if.px_last, 0);
    chk("rst_data", px_if.px_data, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // 1: two-pixel frame
    px_if.px_ready = 1'b1;
    send(8'hA5);
    send(8'h00);
    chk("t1_fstart", frame_start, 1);
    chk("t1_busy", busy, 1);
    send(8'h02);
    chk("t1_fstart_pulse", frame_start, 0);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66);
    step(1'b0, 8'h00);
    chk("t1_fdone", frame_done, 1);
    chk("t1_busy_end", busy, 0);
    step(1'b0, 8'h00);
    chk("t1_fdone_pulse", frame_done, 0);
    idle(3);
    chk("t1_count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      chk("t1_px0", got_data[0], 24'h112233);
      chk("t1_last0", got_last[0], 0);
      chk("t1_px1", got_data[1], 24'h445566);
      chk("t1_last1", got_last[1], 1);
    end
    chk("t1_ovf", overflow, 0);

    // 2: junk bytes then zero-length frame
    got_data.delete(); got_last.delete();
    send(8'h00);
    send(8'hFF);
    send(8'hA5);
    chk("t2_junk_fstart", frame_start, 0);
    chk("t2_junk_busy", busy, 0);
    send(8'h00);
    chk("t2_fstart", frame_start, 1);
    send(8'h00);
    step(1'b0, 8'h00);
    chk("t2_fdone", frame_done, 1);
    chk("t2_busy", busy, 0);
    step(1'b0, 8'h00);
    chk("t2_fdone_pulse", frame_done, 0);
    idle(2);
    chk("t2_valid", px_if.px_valid, 0);
    chk("t2_count", got_data.size(), 0);

    // 3: 20 pixels into 16-entry FIFO with no consumer
    got_data.delete(); got_last.delete();
    px_if.px_ready = 1'b0;
    send(8'hA5); send(8'h00); send(8'd20);
    for (int k = 0; k < 20; k++) begin
      p = pat(k);
      send(p[23:16]); send(p[15:8]); send(p[7:0]);
    end
    step(1'b0, 8'h00);
    chk("t3_fdone", frame_done, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_valid", px_if.px_valid, 1);
    step(1'b0, 8'h00);
    px_if.px_ready = 1'b1;
    idle(20);
    px_if.px_ready = 1'b0;
    chk("t3_count", got_data.size(), 16);
    if (got_data.size() == 16) begin
      n_last = 0;
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("t3_px%0d", k), got_data[k], pat(k));
        if (got_last[k]) n_last++;
      end
      chk("t3_no_last", n_last, 0);
    end
    chk("t3_drained", px_if.px_valid, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: full FIFO, consumer ready exactly on the completing edge
    got_data.delete(); got_last.delete();
    send(8'hA5);
    send(8'h00);
    chk("t3_ovf_clear", overflow, 0);
    chk("t4_fstart", frame_start, 1);
    send(8'd17);
    for (int k = 0; k < 16; k++) begin
      p = pat(k);
      send(p[23:16]); send(p[15:8]); send(p[7:0]);
    end
    p = pat(16);
    send(p[23:16]);
    send(p[15:8]);
    send(p[7:0]);
    px_if.px_ready = 1'b1;
    step(1'b0, 8'h00);
    px_if.px_ready = 1'b0;
    chk("t4_fdone", frame_done, 1);
    chk("t4_ovf", overflow, 0);
    chk("t4_popped", got_data.size(), 1);
    idle(1);
    chk("t4_still_full", px_if.px_valid, 1);
    px_if.px_ready = 1'b1;
    idle(20);
    chk("t4_count", got_data.size(), 17);
    if (got_data.size() == 17) begin
      n_last = 0;
      for (int k = 0; k < 17; k++) begin
        chk($sformatf("t4_px%0d", k), got_data[k], pat(k));
        if (got_last[k]) n_last++;
      end
      chk("t4_last_at_end", got_last[16], 1);
      chk("t4_one_last", n_last, 1);
    end

    // 5: asynchronous reset mid-frame
    got_data.delete(); got_last.delete();
    send(8'hA5); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
    chk("t5_busy_pre", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", px_if.px_valid, 0);
    chk("t5_rst_last", px_if.px_last, 0);
    chk("t5_rst_data", px_if.px_data, 0);
    chk("t5_rst_fstart", frame_start, 0);
    chk("t5_rst_fdone", frame_done, 0);
    chk("t5_rst_ovf", overflow, 0);
    chk("t5_rst_busy", busy, 0);
    in_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send(8'h33);
    send(8'h44);
    step(1'b0, 8'h00);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_fstart", frame_start, 0);
    step(1'b0, 8'h00);
    chk("t5_no_fdone", frame_done, 0);
    chk("t5_no_valid", px_if.px_valid, 0);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03);
    step(1'b0, 8'h00);
    chk("t5_fdone", frame_done, 1);
    idle(3);
    chk("t5_count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      chk("t5_px", got_data[0], 24'h010203);
      chk("t5_last", got_last[0], 1);
    end

    // 6: payload bytes equal to the sync value
    got_data.delete(); got_last.delete();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hA5); send(8'hA5); send(8'hA5);
    step(1'b0, 8'h00);
    chk("t6_fdone", frame_done, 1);
    chk("t6_busy", busy, 0);
    idle(3);
    chk("t6_count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      chk("t6_px", got_data[0], 24'hA5A5A5);
      chk("t6_last", got_last[0], 1);
    end
    chk("t6_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/smi_frame_rx.md
Name: smi_frame_rx

Overview:
- Sits directly downstream of the SMI bus interface.
- Consumes the byte stream the interface produces: one data byte plus a one-cycle write strobe per Pi bus write.
- Parses a framed packet (sync, 16-bit pixel count, pixel bytes) and packs bytes into pixels.
- Buffers pixels in a first-word-fall-through FIFO and presents them to the LED driver on a valid/ready handshake.

Parameters:
BYTES_PER_PIXEL, 3, bytes packed into one pixel word; first received byte lands in the MSBs.
FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 2.
SYNC_BYTE, 8'hA5, byte that starts a frame when idle.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
in_data  input  8  byte from SMI interface, valid when in_write = 1.
in_write  input  1  byte strobe; one byte accepted per cycle it is high.
px_data  output  8*BYTES_PER_PIXEL  FIFO head pixel.
px_last  output  1  head pixel is the final pixel of its frame.
px_valid  output  1  FIFO non-empty.
px_ready  input  1  consumer accepts head when px_valid & px_ready.
frame_start  output  1  one-cycle pulse: valid sync accepted.
frame_done  output  1  one-cycle pulse: final pixel of frame pushed or dropped, or zero-length header done.
overflow  output  1  sticky: at least one pixel dropped because the FIFO was full.
busy  output  1  parser not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state IDLE, FIFO empty, byte counter and pixel counter 0, partial pixel discarded.
  - px_valid, px_last, frame_start, frame_done, overflow, busy = 0; px_data = 0.
  - Reset mid-frame discards the frame. No frame_done is issued for it.
- Byte consumption: only on rising edges with in_write = 1. in_data is ignored otherwise.
- State machine:
  - IDLE: in_write & in_data == SYNC_BYTE -> LEN_HI. Same edge clears overflow; frame_start is high the following cycle. Any other byte is ignored and the state stays IDLE.
  - LEN_HI: byte -> len[15:8]; go to LEN_LO.
  - LEN_LO: byte -> len[7:0].
    - If {len_hi, byte} == 0: go to IDLE; frame_done high the next cycle.
    - Else: go to PIXEL with remaining = len, byte index 0.
  - PIXEL: each byte shifts into the pixel accumulator (MSB first).
    - The byte with index BYTES_PER_PIXEL-1 completes a pixel. On that same edge, {accumulated, in_data} is written to the FIFO, with px_last = (remaining == 1). Byte index returns to 0 and remaining decrements.
    - When remaining reaches 0: go to IDLE; frame_done high the next cycle.
    - SYNC_BYTE values in PIXEL are ordinary data; there is no resynchronisation.
- FIFO:
  - First-word-fall-through. px_valid rises the cycle after the first push into an empty FIFO.
  - Pop on the edge where px_valid & px_ready.
  - Full with a push and no pop on the same edge: pixel dropped, overflow set. Counters still advance, so framing stays aligned and frame_done still fires.
  - Full with push and pop on the same edge: both happen; occupancy unchanged; no drop.
  - Empty with px_ready high: no pop; occupancy stays 0.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
- busy = (state != IDLE), registered.
- Pulse widths: frame_start and frame_done are exactly one cycle wide.
- Back-to-back frames: a sync byte on the cycle right after the final pixel byte is accepted, because the state is already IDLE.
- Throughput: one byte per cycle sustained; no backpressure toward the SMI side. Drops are signalled only through overflow.

Test Plan:
1. Reset, then bytes A5,00,02,11,22,33,44,55,66 on consecutive strobes, px_ready = 1:
   - frame_start 1 cycle after A5.
   - Pixels 0x112233 (last = 0) then 0x445566 (last = 1).
   - frame_done 1 cycle after 0x66; overflow = 0; busy returns to 0.
2. Bytes 00,FF,A5,00,00 -> first two ignored; frame_start, then frame_done one cycle after the second 00; no pixels; px_valid stays 0.
3. px_ready = 0, frame of 20 pixels (FIFO_DEPTH 16):
   - 16 pixels stored; last 4 dropped.
   - overflow = 1 and frame_done still pulses.
   - Draining yields pixels 0–15, with px_last = 0 on all of them.
   - The next A5 clears overflow.
4. FIFO full, px_ready = 1 on the exact edge a pixel completes -> pixel stored, no overflow, occupancy stays 16.
5. Assert reset after A5,00,03,11,22 -> all outputs 0 immediately (asynchronous). After release, bytes 33,44 are ignored in IDLE and a fresh frame parses correctly.
6. Pixel payload containing A5 (A5,00,01,A5,A5,A5) -> one pixel 0xA5A5A5 with px_last = 1; no resync.
